array_key_scan: RTL

Scans a 4x4 active-low matrix keypad and turns presses into debounced key events. It sits directly downstream of the 20 kHz clock divider: it consumes that divider's clk_20k output as a scan-rate strobe, not as a clock. One row advances per strobe. A key is reported only after it reads identically across DEB_SCANS consecutive full scans. Events go to the display and control logic as a one-cycle valid pulse plus a 4-bit key code.

---
 rtl/array_key_pkg.sv | 8 +
 rtl/array_key_debounce.sv | 93 +++++++++
 rtl/array_key_scan.sv | 89 ++++++++
 3 files changed

// File: rtl/array_key_pkg.sv
// rtl/array_key_pkg.sv - shared constants and types for the 4x4 keypad scanner
package array_key_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} deb_state_e;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} scan_res_e;
endpackage

// File: rtl/array_key_debounce.sv
// rtl/array_key_debounce.sv - per-scan press/release debounce FSM with registered key outputs
module array_key_debounce
  import array_key_pkg::*;
#(
  parameter int DEB_SCANS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_done,
  input  scan_res_e  scan_res,
  input  logic [3:0] scan_code,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);
  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_SCANS);

  deb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    cand_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic          key_down_q;

  // Saturating increment: the count never wraps past DEB_SCANS.
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_down_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done) begin
        case (state_q)
          IDLE: begin
            if (scan_res == RES_SINGLE) begin
              cand_q  <= scan_code;
              cnt_q   <= CW'(1);
              state_q <= DEB_PRESS;
            end
          end
          DEB_PRESS: begin
            if (scan_res == RES_SINGLE && scan_code == cand_q) begin
              cnt_q <= cnt_d;
              if (cnt_d == CNT_MAX) begin
                state_q     <= PRESSED;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_down_q  <= 1'b1;
              end
            end else if (scan_res == RES_SINGLE) begin
              cand_q <= scan_code;
              cnt_q  <= CW'(1);
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          PRESSED: begin
            if (scan_res == RES_NONE) begin
              cnt_q   <= CW'(1);
              state_q <= DEB_REL;
            end
          end
          DEB_REL: begin
            if (scan_res == RES_NONE) begin
              cnt_q <= cnt_d;
              if (cnt_d == CNT_MAX) begin
                state_q    <= IDLE;
                key_down_q <= 1'b0;
              end
            end else begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_down  = key_down_q;
endmodule

// File: rtl/array_key_scan.sv
// rtl/array_key_scan.sv - 4x4 active-low keypad row scanner feeding the debounce FSM
module array_key_scan
  import array_key_pkg::*;
#(
  parameter int DEB_SCANS = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_20k,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic            key_valid,
  output logic [3:0]      key_code,
  output logic            key_down
);
  logic            clk_20k_q;
  logic [1:0]      row_idx_q;
  logic [1:0]      acc_n_q;
  logic [1:0]      acc_n_d;
  logic [3:0]      acc_code_q;
  logic [3:0]      acc_code_d;
  logic            tick;
  logic            scan_done;
  logic [COLS-1:0] hits;
  logic [1:0]      row_n;
  logic [1:0]      row_col;
  scan_res_e       scan_res;

  assign tick      = clk_20k & ~clk_20k_q;
  assign scan_done = tick && (row_idx_q == 2'd3);
  assign row_out   = ~(ROWS'(1) << row_idx_q);
  assign hits      = ~col_in;

  // Hit counts saturate at 2: anything beyond one hit is simply MULTI.
  always_comb begin
    row_n   = 2'd0;
    row_col = 2'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (hits[c]) row_col = 2'(c);
    end
    if (hits == '0)        row_n = 2'd0;
    else if ($onehot(hits)) row_n = 2'd1;
    else                    row_n = 2'd2;

    if (acc_n_q == 2'd0)    acc_n_d = row_n;
    else if (row_n == 2'd0) acc_n_d = acc_n_q;
    else                    acc_n_d = 2'd2;

    acc_code_d = (acc_n_q == 2'd0 && row_n == 2'd1) ? {row_idx_q, row_col} : acc_code_q;

    case (acc_n_d)
      2'd0:    scan_res = RES_NONE;
      2'd1:    scan_res = RES_SINGLE;
      default: scan_res = RES_MULTI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_20k_q  <= 1'b1;
      row_idx_q  <= 2'd0;
      acc_n_q    <= 2'd0;
      acc_code_q <= 4'd0;
    end else begin
      clk_20k_q <= clk_20k;
      if (tick) begin
        row_idx_q <= row_idx_q + 2'd1;
        if (row_idx_q == 2'd3) begin
          acc_n_q    <= 2'd0;
          acc_code_q <= 4'd0;
        end else begin
          acc_n_q    <= acc_n_d;
          acc_code_q <= acc_code_d;
        end
      end
    end
  end

  array_key_debounce #(.DEB_SCANS(DEB_SCANS)) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .scan_done (scan_done),
    .scan_res  (scan_res),
    .scan_code (acc_code_d),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down)
  );
endmodule
